// File: rtl/disp_pkg.sv
// Shared types, anode patterns and default timing for the disp_scan_ctrl display scanner.
package disp_pkg;

    typedef enum logic [1:0] {
        D0 = 2'd0,
        D1 = 2'd1,
        D2 = 2'd2,
        D3 = 2'd3
    } digit_t;

    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [3:0] ANODE_D3  = 4'b0111;
    localparam logic [3:0] ANODE_D2  = 4'b1011;
    localparam logic [3:0] ANODE_D1  = 4'b1101;
    localparam logic [3:0] ANODE_D0  = 4'b1110;

    localparam int DEF_SLOT_CYCLES  = 50000;
    localparam int DEF_GAP_CYCLES   = 500;
    localparam int DEF_BLINK_FRAMES = 64;

    function automatic logic [3:0] anode_of(digit_t d);
        case (d)
            D3:      return ANODE_D3;
            D2:      return ANODE_D2;
            D1:      return ANODE_D1;
            default: return ANODE_D0;
        endcase
    endfunction

    // Scan order is D3 -> D2 -> D1 -> D0 -> D3, i.e. a 2-bit down-count.
    function automatic digit_t next_digit(digit_t d);
        return digit_t'(d - 2'd1);
    endfunction

endpackage

// File: rtl/disp_scan_ctrl_slot_timer.sv
// Timebase for disp_scan_ctrl: slot counter with anti-ghost gap, free-running PWM phase,
// and the frame divider that toggles the blink phase.
module disp_slot_timer
    import disp_pkg::*;
#(
    parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       last_slot,
    output logic       slot_end,
    output logic       frame_end,
    output logic       in_gap,
    output logic [3:0] pwm,
    output logic       blink_phase
);

    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_CYCLES - 1);
    localparam logic [SW-1:0] GAP_END    = SW'(GAP_CYCLES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [SW-1:0] slot_cnt;
    logic [FW-1:0] frame_cnt;

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && last_slot;
    assign in_gap    = (slot_cnt < GAP_END);

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt    <= '0;
            pwm         <= 4'd0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            pwm      <= pwm + 4'd1;
            slot_cnt <= slot_end ? '0 : slot_cnt + SW'(1);
            if (frame_end) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed display scanner with tear-free double-buffered image load,
// PWM brightness and blink. Optional leading-zero blanking: define DISP_LZ_BLANK_EN.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
    parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic [3:0]  load_blank,
    input  logic [3:0]  blink_mask,
    input  logic [3:0]  bright,
    output logic [3:0]  muxd,
    output logic [3:0]  adrive,
    output logic        frame_start
);

    digit_t      state;
    logic [15:0] pend_data;
    logic [3:0]  pend_blank;
    logic [15:0] com_data;
    logic [3:0]  com_blank;
    logic        boundary_q;

    logic        slot_end;
    logic        frame_end;
    logic        in_gap;
    logic [3:0]  pwm;
    logic        blink_phase;
    logic [3:0]  lz_mask;
    logic        lit;

    disp_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .last_slot   (state == D0),
        .slot_end    (slot_end),
        .frame_end   (frame_end),
        .in_gap      (in_gap),
        .pwm         (pwm),
        .blink_phase (blink_phase)
    );

`ifdef DISP_LZ_BLANK_EN
    // Zeros ahead of the first nonzero digit go dark; the units digit always shows.
    logic lz3, lz2, lz1;
    assign lz3     = (com_data[15:12] == 4'h0);
    assign lz2     = lz3 && (com_data[11:8] == 4'h0);
    assign lz1     = lz2 && (com_data[7:4] == 4'h0);
    assign lz_mask = {lz3, lz2, lz1, 1'b0};
`else
    assign lz_mask = 4'b0000;
`endif

    assign lit = !in_gap
              && (pwm <= bright)
              && !com_blank[state]
              && !(blink_phase && blink_mask[state])
              && !lz_mask[state];

    // load_ready doubles as "pending empty", so a transfer can never coincide with a commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= D3;
            // NOTE: the pending image is cleared on reset too, so no stale data can ever commit.
            pend_data   <= 16'h0000;
            pend_blank  <= 4'b0000;
            com_data    <= 16'h0000;
            com_blank   <= 4'b1111;
            load_ready  <= 1'b1;
            muxd        <= 4'h0;
            adrive      <= ANODE_OFF;
            boundary_q  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (slot_end) begin
                state <= next_digit(state);
            end

            if (frame_end && !load_ready) begin
                com_data   <= pend_data;
                com_blank  <= pend_blank;
                load_ready <= 1'b1;
            end else if (load_valid && load_ready) begin
                pend_data  <= load_data;
                pend_blank <= load_blank;
                load_ready <= 1'b0;
            end

            muxd        <= com_data[{state, 2'b00} +: 4];
            adrive      <= lit ? anode_of(state) : ANODE_OFF;
            boundary_q  <= frame_end;
            frame_start <= boundary_q;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl (SLOT=8, GAP=2, BLINK=2): stimulus queues timed
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_disp_scan_ctrl;

    localparam int SLOT  = 8;
    localparam int GAP   = 2;
    localparam int FRAME = 4 * SLOT;

`ifdef DISP_LZ_BLANK_EN
    localparam bit LZ_ON = 1'b1;
`else
    localparam bit LZ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [15:0] load_data = 16'hDEAD;
    logic [3:0]  load_blank = 4'hA;
    logic [3:0]  blink_mask = 4'h0;
    logic [3:0]  bright = 4'hF;
    logic [3:0]  muxd;
    logic [3:0]  adrive;
    logic        frame_start;

    typedef enum {K_AD, K_MX, K_RDY, K_FS} kind_e;
    typedef struct {
        int         t;
        kind_e      kind;
        logic [3:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   tn = -1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    disp_scan_ctrl #(
        .SLOT_CYCLES  (SLOT),
        .GAP_CYCLES   (GAP),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_blank  (load_blank),
        .blink_mask  (blink_mask),
        .bright      (bright),
        .muxd        (muxd),
        .adrive      (adrive),
        .frame_start (frame_start)
    );

    // tn = index of the internal cycle the registered outputs currently show (-1: reset).
    always @(posedge clk) begin
        if (reset) tn <= -1;
        else       tn <= tn + 1;
    end

    task automatic check(string name, logic [3:0] act, logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].t <= tn) begin
            e = sb.pop_front();
            if (e.t < tn) begin
                n_vec++;
                n_bad++;
                $display("FAIL %s: sampled late at t%0d", e.name, tn);
            end else begin
                case (e.kind)
                    K_AD:    check(e.name, adrive, e.exp);
                    K_MX:    check(e.name, muxd, e.exp);
                    K_RDY:   check(e.name, {3'b000, load_ready}, e.exp);
                    default: check(e.name, {3'b000, frame_start}, e.exp);
                endcase
            end
        end
    end

    task automatic push(int t, kind_e k, logic [3:0] v, string nm);
        exp_t e;
        int   i;
        e.t    = t;
        e.kind = k;
        e.exp  = v;
        e.name = $sformatf("%s@t%0d", nm, t);
        i = sb.size();
        while (i > 0 && sb[i-1].t > t) i--;
        sb.insert(i, e);
    endtask

    function automatic int dig(int t);
        return 3 - (t % FRAME) / SLOT;
    endfunction

    function automatic logic [3:0] onecold(int d);
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [3:0] nib(logic [15:0] v, int d);
        return v[d*4 +: 4];
    endfunction

    task automatic wait_t(int target);
        int guard;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (tn != target && guard < 1000);
        if (tn != target) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_t: at t%0d, required t%0d", tn, target);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        load_valid = 1'b0;
        repeat (2) @(posedge clk);
        push(-1, K_AD,  4'hF, "rst_adrive");
        push(-1, K_MX,  4'h0, "rst_muxd");
        push(-1, K_RDY, 4'h1, "rst_ready");
        push(-1, K_FS,  4'h0, "rst_fstart");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic offer(logic [15:0] d, logic [3:0] b, int at);
        wait_t(at);
        load_valid = 1'b1;
        load_data  = d;
        load_blank = b;
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = 16'hDEAD;
        load_blank = 4'hA;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, first %s", sb.size(), sb[0].name);
            sb.delete();
        end
    endtask

    initial begin
        int guard;

        // Basic image 1234 at full brightness, shown in frame 1.
        do_reset();
        bright = 4'hF;
        blink_mask = 4'h0;
        for (int t = 0; t < FRAME; t += 5) push(t, K_AD, 4'hF, "s1_dark_precommit");
        push(6, K_RDY, 4'h0, "s1_ready_low");
        push(30, K_RDY, 4'h0, "s1_ready_held");
        push(31, K_RDY, 4'h1, "s1_ready_back");
        push(31, K_FS, 4'h0, "s1_fstart_pre");
        push(32, K_FS, 4'h1, "s1_fstart");
        push(33, K_FS, 4'h0, "s1_fstart_post");
        push(64, K_FS, 4'h1, "s1_fstart_f2");
        for (int t = 32; t < 64; t++) begin
            push(t, K_AD, (t % SLOT >= GAP) ? onecold(dig(t)) : 4'hF, "s1_adrive");
            push(t, K_MX, nib(16'h1234, dig(t)), "s1_muxd");
        end
        offer(16'h1234, 4'h0, 5);
        drain();

        // Back-to-back offer: second image waits for the commit, shows a frame later.
        do_reset();
        push(6, K_RDY, 4'h0, "s2_ready_low");
        push(31, K_RDY, 4'h1, "s2_ready_commit");
        push(32, K_RDY, 4'h0, "s2_ready_second");
        push(62, K_RDY, 4'h0, "s2_ready_held");
        push(63, K_RDY, 4'h1, "s2_ready_commit2");
        for (int t = 32; t < 64; t += 3) push(t, K_MX, nib(16'h1234, dig(t)), "s2_muxd_a");
        for (int t = 64; t < 96; t += 3) push(t, K_MX, nib(16'h5678, dig(t)), "s2_muxd_b");
        push(98, K_AD, 4'b0111, "s2_adrive_b");
        wait_t(5);
        load_valid = 1'b1;
        load_data  = 16'h1234;
        load_blank = 4'h0;
        @(negedge clk);
        load_data = 16'h5678;
        guard = 0;
        while (!load_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!load_ready) begin
            n_vec++;
            n_bad++;
            $display("FAIL s2_wait_ready: load_ready stayed 0");
        end
        @(negedge clk);
        load_valid = 1'b0;
        load_data  = 16'hDEAD;
        drain();

        // Leading zeros: 0050.
        do_reset();
        for (int t = 32; t < 64; t++)
            push(t, K_AD, ((t % SLOT < GAP) || (LZ_ON && dig(t) >= 2)) ? 4'hF : onecold(dig(t)),
                 "s3_adrive_lz");
        push(33, K_MX, 4'h0, "s3_muxd_d3");
        push(45, K_MX, 4'h0, "s3_muxd_d2");
        push(50, K_MX, 4'h5, "s3_muxd_d1");
        push(60, K_MX, 4'h0, "s3_muxd_d0");
        offer(16'h0050, 4'h0, 5);
        drain();

        // Blink on D0, with a live mask change in frame 3.
        do_reset();
        blink_mask = 4'b0001;
        for (int f = 1; f <= 5; f++) begin
            push(f*FRAME + 2, K_AD, 4'b0111, "s4_d3_unaffected");
            push(f*FRAME + 26, K_AD, (f == 2 || f == 3) ? 4'hF : 4'b1110, "s4_d0_blink");
            push(f*FRAME + 31, K_AD, (f == 2 || f == 3) ? 4'hF : 4'b1110, "s4_d0_blink_end");
        end
        push(123, K_AD, 4'hF, "s4_mask_before");
        push(124, K_AD, 4'b1110, "s4_mask_cleared");
        push(125, K_AD, 4'b1110, "s4_mask_cleared2");
        push(126, K_AD, 4'hF, "s4_mask_restored");
        offer(16'h1234, 4'h0, 5);
        wait_t(123);
        blink_mask = 4'b0000;
        wait_t(125);
        blink_mask = 4'b0001;
        drain();
        blink_mask = 4'b0000;

        // Brightness 3, then live changes to 15 and 0.
        do_reset();
        bright = 4'd3;
        for (int t = 32; t < 64; t++)
            push(t, K_AD, (t == 34 || t == 35) ? 4'b0111 :
                          (t == 50 || t == 51) ? 4'b1101 : 4'hF, "s5_bright3");
        push(64, K_AD, 4'hF, "s5_b15_gap");
        push(66, K_AD, 4'b0111, "s5_b15_pwm2");
        push(68, K_AD, 4'b0111, "s5_b15_pwm4");
        push(71, K_AD, 4'b0111, "s5_b15_pwm7");
        push(79, K_AD, 4'b1011, "s5_b15_pwm15");
        push(82, K_AD, 4'hF, "s5_b0_pwm2");
        push(83, K_AD, 4'hF, "s5_b0_pwm3");
        offer(16'h1234, 4'h0, 5);
        wait_t(63);
        bright = 4'd15;
        wait_t(79);
        bright = 4'd0;
        drain();
        bright = 4'hF;

        // Reset mid-D1 with a pending image: nothing stale may commit afterwards.
        do_reset();
        push(42, K_AD, 4'b1011, "s6_lit_before");
        push(36, K_RDY, 4'h0, "s6_pending");
        push(45, K_RDY, 4'h0, "s6_pending_held");
        offer(16'h1234, 4'h0, 5);
        offer(16'h5678, 4'h0, 35);
        wait_t(49);
        do_reset();
        for (int t = 0; t < 2*FRAME; t += 3) push(t, K_AD, 4'hF, "s6_dark_after_reset");
        for (int t = 32; t < 40; t++) push(t, K_AD, 4'hF, "s6_no_stale_d3");
        push(10, K_RDY, 4'h1, "s6_ready_idle");
        push(40, K_RDY, 4'h1, "s6_ready_idle2");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- SLOT_CYCLES, 50000, clocks per digit slot; must be >= GAP_CYCLES+1.
- GAP_CYCLES, 500, anti-ghost dark clocks at the start of each slot.
- BLINK_FRAMES, 64, frames per blink half-period.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, sole clock.
- reset, in, 1, synchronous, active-high.
- load_valid, in, 1, new display image offered.
- load_ready, out, 1, image can be accepted.
- load_data, in, 16, nibbles D3..D0 = [15:12]..[3:0].
- load_blank, in, 4, per-digit force-off, bit3 = D3.
- blink_mask, in, 4, digits subject to blinking, sampled live.
- bright, in, 4, duty level, sampled live.
- muxd, out, 4, nibble of the active digit.
- adrive, out, 4, active-low anodes, bit3 = D3.
- frame_start, out, 1, one-cycle pulse at the start of each D3 slot.
REQ-003 Clocking SHALL be one clock, clk; reset is synchronous and active-high.

Function
REQ-004 Scan FSM states SHALL be D3, D2, D1, D0, visited in the order D3->D2->D1->D0->D3; each state lasts exactly SLOT_CYCLES clocks, counted by the slot counter from 0 to SLOT_CYCLES-1.
REQ-005 A free-running 4-bit pwm counter SHALL increment every clock and wrap from 15 to 0.
REQ-006 The active digit anode SHALL be asserted (0) iff all of these hold:
- slot counter >= GAP_CYCLES.
- pwm counter <= bright.
- the digit's committed blank bit is 0.
- the digit is not blink-suppressed.
- the digit is not LZ-blanked.
All other anodes SHALL be 1.
REQ-007 bright=15 SHALL give 16/16 duty in the lit window; bright=0 SHALL give 1/16.
REQ-008 muxd and adrive SHALL be registered, lagging the internal state by exactly 1 clock; muxd SHALL show the active digit's nibble even while that digit is dark.
REQ-009 A frame boundary SHALL be the clock where the FSM leaves D0 for D3; frame_start SHALL be aligned with the first registered D3 output cycle.
REQ-010 Load handshake:
- A transfer occurs on a clock where load_valid && load_ready.
- Data and blank bits go to a pending register; load_ready then drops to 0 the next clock.
REQ-011 At each frame boundary with pending valid:
- Pending data and blank SHALL be copied to the committed registers.
- Pending SHALL be cleared.
- load_ready SHALL be 1 the next clock.
Committed data SHALL never change mid-frame (no tearing).
REQ-012 Simultaneous transfer and boundary: the transfer SHALL go to pending and commit at the following boundary, never the current one.
REQ-013 load_data SHALL be held by the requester only during the transfer cycle; no X propagation is allowed when load_valid=0.
REQ-014 Blink:
- A frame counter SHALL toggle blink_phase after every BLINK_FRAMES frame boundaries.
- When blink_phase=1, digits with blink_mask=1 SHALL be dark.
- When blink_phase=0, blink has no effect.
REQ-015 A blink_mask or bright change SHALL take effect on the next clock; it SHALL NOT wait for a frame boundary.

Reset
REQ-016 While reset is high, on each clk edge the block SHALL set:
- FSM=D3, slot, pwm and frame counters=0, blink_phase=0.
- pending cleared; committed data=16'h0000; committed blank=4'b1111 (dark until first commit).
- adrive=4'b1111, muxd=4'h0, frame_start=0, load_ready=1.
REQ-017 Reset asserted mid-slot or mid-handshake SHALL discard pending data; the first post-reset frame boundary occurs 4*SLOT_CYCLES clocks after reset deasserts.

Configuration
REQ-018 Macro DISP_LZ_BLANK_EN SHALL control leading-zero suppression:
- Defined: starting at D3, each committed zero nibble preceding the first nonzero nibble is LZ-blanked; D0 is never LZ-blanked; evaluation uses committed data only.
- Undefined: no LZ blanking, and the logic SHALL be absent.

Structure
REQ-019 Package disp_pkg SHALL hold:
- the digit-state enum (D3..D0).
- anode constants ANODE_OFF=4'b1111 and per-digit one-cold patterns.
- default parameter values.
REQ-020 Sub-module disp_slot_timer SHALL contain the slot counter, pwm counter and frame/blink counter, and provide slot_end, frame_end, in_gap and blink_phase.

Verification (SLOT_CYCLES=8, GAP_CYCLES=2, BLINK_FRAMES=2)
REQ-021 Load 16'h1234, blank=0, bright=15:
- Next frame shows muxd 1,2,3,4 with adrive 0111,1011,1101,1110.
- Each digit is dark for cycles 0-1 of its slot and lit for cycles 2-7.
REQ-022 Back-to-back offer:
- Second load_valid held while load_ready=0 is not accepted.
- It is accepted the cycle after the commit.
- It is shown one frame later.
REQ-023 Load 16'h0050, blank=0:
- With DISP_LZ_BLANK_EN defined, D3 and D2 stay at 1111; D1 and D0 are lit.
- With the macro undefined, all four digits are lit.
REQ-024 blink_mask=4'b0001: D0 is dark during frames 2-3, lit in frames 0-1 and 4-5; other digits are always lit.
REQ-025 bright=3: adrive for the active digit is 0 only while the pwm counter is 0-3 within the lit window.
REQ-026 Reset asserted mid-D1 with pending valid: adrive=1111 and load_ready=1; after release the display stays dark, with no stale commit.
